// File: rtl/spi_pkg.sv
// Shared widths and FSM encoding for the SPI configuration bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;
    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;
endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for one asynchronous input.
// Latency: STAGES clk cycles.
// Backpressure: none.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave: deserializes MOSI into byte_sync/data_in, serializes data_out on MISO (optional frame_err via SPI_BRIDGE_FRAME_ERR_EN).
// Latency: byte_sync SYNC_STAGES+1 clk after the 8th sclk rise; data_out captured 2 clk after byte_sync.
// Backpressure: none; the SPI master sets the pace and the decoder must keep up.
module spi_bridge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  byte_sync,
    output logic [SPI_BYTE_W-1:0] data_in,
    input  logic [SPI_BYTE_W-1:0] data_out
`ifdef SPI_BRIDGE_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);
    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_fall;

    spi_state_t             state;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt;
    logic [SPI_BYTE_W-2:0]  rx_sr;
    logic [SPI_BYTE_W-1:0]  tx_sr;
    logic [SPI_BYTE_W-1:0]  rx_next;
    logic [1:0]             ld_pipe;

    // cs_n resets to "asserted" so a frame already in flight at reset
    // cannot produce a falling edge; a genuine high-then-low is required.
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign rx_next   = {rx_sr, mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            ld_pipe   <= '0;
            miso      <= 1'b0;
            byte_sync <= 1'b0;
            data_in   <= '0;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            byte_sync <= 1'b0;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    miso    <= 1'b0;
                    ld_pipe <= '0;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
                    frame_err <= sclk_rise;
`endif
                    if (cs_fall) begin
                        state <= ACTIVE;
                        tx_sr <= '0;
                    end
                end
                ACTIVE: begin
                    // cs_n high here always means it just rose; it overrides any sclk edge
                    if (cs_s) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        miso    <= 1'b0;
                        ld_pipe <= '0;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
                        frame_err <= (bit_cnt != '0);
`endif
                    end else begin
                        ld_pipe <= {ld_pipe[0], byte_sync};
                        miso    <= tx_sr[SPI_BYTE_W-1];
                        if (sclk_rise) begin
                            rx_sr   <= rx_next[SPI_BYTE_W-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_in   <= rx_next;
                                byte_sync <= 1'b1;
                            end
                        end
                        // No shift at bit_cnt 0 keeps the freshly loaded MSB on the wire
                        if (ld_pipe[1]) begin
                            tx_sr <= data_out;
                        end else if (sclk_fall && (bit_cnt != '0)) begin
                            tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_bridge.sv
// Directed bench for spi_bridge: table of single-byte frames plus multi-cycle sequences.
module tb_spi_bridge;
    localparam int S    = 2;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi, miso, byte_sync;
    logic [7:0] data_in, data_out;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
    logic       frame_err;
`endif

    always #5 clk = ~clk;

    spi_bridge #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .byte_sync(byte_sync), .data_in(data_in),
        .data_out(data_out)
`ifdef SPI_BRIDGE_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int bs_wide = 0;
    int last_lat = 0;
    int rise_cyc = 0;
    int errs = 0;
    logic bs_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_sync) begin
            pulses   = pulses + 1;
            last_lat = cyc - rise_cyc;
            if (bs_prev) bs_wide = bs_wide + 1;
        end
        bs_prev = byte_sync;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
        if (frame_err) errs = errs + 1;
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side of one byte slot: MOSI set while sclk low, MISO sampled just before the rise
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            ticks(HALF);
            rx[7-i] = miso;
            sclk = 1'b1;
            rise_cyc = cyc;
            ticks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        ticks(S + 4);
    endtask

    task automatic frame_stop();
        ticks(HALF);
        cs_n = 1'b1;
        ticks(S + 8);
    endtask

    typedef struct {
        logic [7:0] tx;
        int         nbits;
        int         exp_pulses;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [7:0] rx, rx1, rx2;
        int p0, e0;
        bit ok;

        vt[0] = '{8'h83, 8, 1, 8'h83};
        vt[1] = '{8'hFF, 5, 0, 8'h83};
        vt[2] = '{8'h3C, 8, 1, 8'h3C};
        vt[3] = '{8'h01, 7, 0, 8'h3C};
        vt[4] = '{8'h00, 8, 1, 8'h00};
        vt[5] = '{8'h80, 1, 0, 8'h00};
        vt[6] = '{8'hA5, 8, 1, 8'hA5};

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; data_out = 8'h5A;
        ticks(4);
        rst = 1'b0;
        ticks(20);
        chk("reset_miso", miso, 0);
        chk("reset_byte_sync", byte_sync, 0);
        chk("reset_data_in", data_in, 8'h00);
        chk("idle_no_pulse", pulses, 0);

        for (int i = 0; i < 7; i++) begin
            p0 = pulses;
            frame_start();
            spi_bits(vt[i].tx, vt[i].nbits, rx);
            frame_stop();
            chk($sformatf("vec%0d_pulses", i), pulses - p0, vt[i].exp_pulses);
            chk($sformatf("vec%0d_data_in", i), data_in, vt[i].exp_data);
            chk($sformatf("vec%0d_miso", i), rx, 8'h00);
            if (vt[i].exp_pulses == 1)
                chk_rng($sformatf("vec%0d_latency", i), last_lat, S, S + 2);
        end

        // Reset mid-frame with cs_n held low: no bits accepted until cs_n cycles
        cs_n = 1'b0;
        ticks(S + 4);
        spi_bits(8'hFF, 4, rx);
        ticks(2);
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        ticks(1);
        chk("midrst_miso", miso, 0);
        chk("midrst_byte_sync", byte_sync, 0);
        chk("midrst_data_in", data_in, 8'h00);
        p0 = pulses;
        spi_bits(8'h3C, 8, rx);
        frame_stop();
        chk("midrst_ignored_pulses", pulses - p0, 0);
        chk("midrst_ignored_data", data_in, 8'h00);
        p0 = pulses;
        frame_start();
        spi_bits(8'h3C, 8, rx);
        frame_stop();
        chk("midrst_restart_pulses", pulses - p0, 1);
        chk("midrst_restart_data", data_in, 8'h3C);

        // Read: decoder answers A5 one cycle after the first byte_sync
        data_out = 8'h00;
        p0 = pulses;
        ok = 1'b0;
        frame_start();
        fork
            begin
                spi_bits(8'h03, 8, rx1);
                spi_bits(8'h00, 8, rx2);
            end
            begin
                for (int k = 0; k < 2000 && !ok; k++) begin
                    @(negedge clk);
                    if (byte_sync) ok = 1'b1;
                end
                @(negedge clk);
                data_out = 8'hA5;
            end
        join
        frame_stop();
        chk("rd_sync_seen", ok, 1);
        chk("rd_pulses", pulses - p0, 2);
        chk("rd_data_in", data_in, 8'h00);
        chk("rd_miso_byte1", rx1, 8'h00);
        chk("rd_miso_byte2", rx2, 8'hA5);

`ifdef SPI_BRIDGE_FRAME_ERR_EN
        e0 = errs;
        frame_start();
        spi_bits(8'hE0, 3, rx);
        frame_stop();
        chk("ferr_abort", errs - e0, 1);
        e0 = errs;
        frame_start();
        spi_bits(8'h42, 8, rx);
        frame_stop();
        chk("ferr_clean", errs - e0, 0);
`else
        e0 = errs;
        chk("ferr_absent", e0, 0);
`endif

        chk("byte_sync_width", bs_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
